// File: rtl/b16_dot_ctrl_pkg.sv
// Shared types, constants and rounding helper for the bfloat16 dot-product block.
package b16_dot_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // bfloat16 field layout
    localparam int BF16_W     = 16;
    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int BF16_BIAS  = 127;

    localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;
    localparam logic [BF16_W-1:0] BF16_ONE  = 16'h3F80;
    localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;

    // Position of the most significant set bit; 0 when no bit is set.
    function automatic logic [4:0] lead_one_pos(input logic [19:0] v);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 20; i++) begin
            if (v[i]) pos = 5'(i);
        end
        return pos;
    endfunction

    // Round-to-nearest-even on a normalised significand, then range check.
    // Results below the normal range flush to signed zero, above go to infinity.
    function automatic logic [BF16_W-1:0] bf16_round_pack(
        input logic               sign,
        input logic signed [10:0] exp,
        input logic [6:0]         frac,
        input logic               guard,
        input logic               sticky
    );
        logic [7:0]         f_sum;
        logic signed [10:0] e_r;
        f_sum = {1'b0, frac} + {7'd0, guard & (sticky | frac[0])};
        // A carry out of the fraction bumps the exponent and leaves frac zero.
        e_r = exp + $signed({10'd0, f_sum[7]});
        if (e_r >= 11'sd255) begin
            return {sign, 8'hFF, 7'h00};
        end else if (e_r <= 11'sd0) begin
            return {sign, 15'h0000};
        end
        return {sign, e_r[7:0], f_sum[6:0]};
    endfunction

endpackage

// File: rtl/b16fpadd.sv
// Combinational bfloat16 adder: RNE rounding, denormals flushed to zero.
module b16fpadd
    import b16_dot_ctrl_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_s
);

    logic               w_a_zero, w_a_inf, w_a_nan;
    logic               w_b_zero, w_b_inf, w_b_nan;
    logic               w_a_ge;
    logic [15:0]        w_x, w_y;
    logic [7:0]         w_d;
    logic [19:0]        w_wx, w_wy_full, w_wy, w_sum;
    logic               w_eff_sub;
    logic [4:0]         w_lead, w_shamt;
    logic [18:0]        w_norm;
    logic signed [10:0] w_exp;
    logic [15:0]        w_rounded;

    // Align the smaller operand with a sticky jam, add/subtract, renormalise, round.
    always_comb begin
        w_a_zero = (i_a[14:7] == 8'h00);
        w_b_zero = (i_b[14:7] == 8'h00);
        w_a_inf  = (i_a[14:7] == 8'hFF) && (i_a[6:0] == 7'h00);
        w_b_inf  = (i_b[14:7] == 8'hFF) && (i_b[6:0] == 7'h00);
        w_a_nan  = (i_a[14:7] == 8'hFF) && (i_a[6:0] != 7'h00);
        w_b_nan  = (i_b[14:7] == 8'hFF) && (i_b[6:0] != 7'h00);

        w_a_ge = (i_a[14:0] >= i_b[14:0]);
        w_x    = w_a_ge ? i_a : i_b;
        w_y    = w_a_ge ? i_b : i_a;
        w_d    = w_x[14:7] - w_y[14:7];

        // Significand sits at bits 18:11, leaving 11 guard bits and a carry bit.
        w_wx      = {1'b0, 1'b1, w_x[6:0], 11'd0};
        w_wy_full = {1'b0, 1'b1, w_y[6:0], 11'd0};
        if (w_d >= 8'd20) begin
            w_wy = 20'd1;
        end else begin
            w_wy = (w_wy_full >> w_d)
                 | {19'd0, |(w_wy_full & ~(20'hFFFFF << w_d))};
        end

        w_eff_sub = w_x[15] ^ w_y[15];
        w_sum     = w_eff_sub ? (w_wx - w_wy) : (w_wx + w_wy);
        w_lead    = lead_one_pos(w_sum);
        w_shamt   = 5'd19 - w_lead;
        // Hidden bit shifts out of the top; what remains is fraction, guard, sticky.
        w_norm    = w_sum[18:0] << w_shamt;
        w_exp     = $signed({3'd0, w_x[14:7]}) + $signed({6'd0, w_lead}) - 11'sd18;
        w_rounded = bf16_round_pack(w_x[15], w_exp, w_norm[18:12], w_norm[11], |w_norm[10:0]);

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15]))) begin
            o_s = BF16_QNAN;
        end else if (w_a_inf) begin
            o_s = i_a;
        end else if (w_b_inf) begin
            o_s = i_b;
        end else if (w_a_zero && w_b_zero) begin
            o_s = {i_a[15] & i_b[15], 15'h0000};
        end else if (w_a_zero) begin
            o_s = i_b;
        end else if (w_b_zero) begin
            o_s = i_a;
        end else if (w_sum == 20'd0) begin
            o_s = BF16_ZERO;
        end else begin
            o_s = w_rounded;
        end
    end

endmodule

// File: rtl/b16fpmul.sv
// Combinational bfloat16 multiplier: RNE rounding, denormals flushed to zero.
module b16fpmul
    import b16_dot_ctrl_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_p
);

    logic               w_sign;
    logic               w_a_zero, w_a_inf, w_a_nan;
    logic               w_b_zero, w_b_inf, w_b_nan;
    logic [15:0]        w_prod;
    logic signed [10:0] w_exp;
    logic [6:0]         w_frac;
    logic               w_guard, w_sticky;
    logic [15:0]        w_rounded;

    // Classify operands, form the significand product and pick the result.
    always_comb begin
        w_sign   = i_a[15] ^ i_b[15];
        w_a_zero = (i_a[14:7] == 8'h00);
        w_b_zero = (i_b[14:7] == 8'h00);
        w_a_inf  = (i_a[14:7] == 8'hFF) && (i_a[6:0] == 7'h00);
        w_b_inf  = (i_b[14:7] == 8'hFF) && (i_b[6:0] == 7'h00);
        w_a_nan  = (i_a[14:7] == 8'hFF) && (i_a[6:0] != 7'h00);
        w_b_nan  = (i_b[14:7] == 8'hFF) && (i_b[6:0] != 7'h00);

        w_prod = {1'b1, i_a[6:0]} * {1'b1, i_b[6:0]};
        w_exp  = $signed({3'd0, i_a[14:7]}) + $signed({3'd0, i_b[14:7]})
               - 11'(BF16_BIAS) + $signed({10'd0, w_prod[15]});

        // Product of two [1,2) significands lies in [1,4); bit 15 marks the upper half.
        if (w_prod[15]) begin
            w_frac   = w_prod[14:8];
            w_guard  = w_prod[7];
            w_sticky = |w_prod[6:0];
        end else begin
            w_frac   = w_prod[13:7];
            w_guard  = w_prod[6];
            w_sticky = |w_prod[5:0];
        end
        w_rounded = bf16_round_pack(w_sign, w_exp, w_frac, w_guard, w_sticky);

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            o_p = BF16_QNAN;
        end else if (w_a_inf || w_b_inf) begin
            o_p = {w_sign, 8'hFF, 7'h00};
        end else if (w_a_zero || w_b_zero) begin
            o_p = {w_sign, 15'h0000};
        end else begin
            o_p = w_rounded;
        end
    end

endmodule

// File: rtl/b16_dot_ctrl.sv
// bfloat16 dot-product sequencer: issues buffer reads, multiplies each pair and
// accumulates the products strictly left-to-right from +0.
module b16_dot_ctrl
    import b16_dot_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [15:0]       i_rd_data_a,
    input  logic [15:0]       i_rd_data_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_result
);

    state_t              r_state;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [15:0]         r_result;

    logic                r_rv;
    logic                r_prod_v;
    logic [15:0]         r_prod;
    logic [15:0]         r_acc;

    logic                w_accept;
    logic [15:0]         w_mul;
    logic [15:0]         w_sum;

    assign w_accept = (r_state == S_IDLE) && i_start;

    b16fpmul u_mul (
        .i_a (i_rd_data_a),
        .i_b (i_rd_data_b),
        .o_p (w_mul)
    );

    b16fpadd u_add (
        .i_a (r_acc),
        .i_b (r_prod),
        .o_s (w_sum)
    );

    // Command FSM: address counter, read strobe, busy/done and result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= BF16_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd_addr <= i_base_addr;
                        r_cnt     <= i_length - LEN_W'(1);
                        r_busy    <= 1'b1;
                        r_result  <= BF16_ZERO;
                        if (i_length != '0) begin
                            r_state <= S_ISSUE;
                            r_rd_en <= 1'b1;
                        end else begin
                            // Empty pipeline drains in one cycle, giving done at edge 1.
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == '0) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        r_cnt     <= r_cnt - LEN_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!r_rv && !r_prod_v) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= r_acc;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: read-valid delay, registered product, serial accumulate.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rv     <= 1'b0;
            r_prod_v <= 1'b0;
            r_prod   <= BF16_ZERO;
            r_acc    <= BF16_ZERO;
        end else begin
            r_rv     <= r_rd_en;
            r_prod_v <= r_rv;
            if (r_rv) begin
                r_prod <= w_mul;
            end
            if (w_accept) begin
                r_acc <= BF16_ZERO;
            end else if (r_prod_v) begin
                r_acc <= w_sum;
            end
        end
    end

    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_result  = r_result;

endmodule
